// File: rtl/spi_flash_reader.sv
// spi_flash_reader: single-I/O SPI flash read initiator.
// Wakes the flash with 0xAB after reset, then serves READ (0x03) requests
// and streams bytes out over a ready/valid port with SCK-level backpressure.
module spi_flash_reader #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned GAP_CYC  = 4,
  parameter int unsigned WAKE_CYC = 16
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_len,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

  typedef enum logic [2:0] {
    WAKE_CMD,
    WAKE_WAIT,
    READY,
    CMD,
    ADDR,
    DATA,
    END,
    GAP
  } state_t;

  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYC - 1);
  localparam logic [15:0] WAKE_LOAD = 16'(GAP_CYC + WAKE_CYC - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [31:0] sh_out;
  logic [5:0]  bit_cnt;
  logic [6:0]  sh_in;
  logic [2:0]  dbit;
  logic [8:0]  len_left;
  logic [15:0] wait_cnt;

  logic tick, rise, fall, sample, stall, data_done;

  // SCK edge decode, sample strobe and backpressure stall
  always_comb begin
    tick   = (div_cnt == DIV_LAST);
    rise   = tick && !flash_clk;
    fall   = tick && flash_clk;
    // first cycle SCK is high: the flash has held MISO since the last fall
    sample = (state == DATA) && flash_clk && (div_cnt == '0);
    // hold SCK low before the 8th edge while the output byte is still unread
    stall  = (state == DATA) && (dbit == 3'd7) && rd_valid && !rd_ready;
    // with CLK_DIV=1 the final sample and the following fall share a cycle
    data_done = (len_left == '0) ||
                (sample && (dbit == 3'd7) && (len_left == 9'd1));
  end

  // Main FSM with registered SPI pins and stream outputs
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state     <= WAKE_CMD;
      flash_csb <= 1'b1;
      flash_clk <= 1'b0;
      flash_io0 <= 1'b0;
      req_ready <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      busy      <= 1'b1;
      div_cnt   <= '0;
      sh_out    <= {8'hAB, 24'h000000};
      bit_cnt   <= '0;
      sh_in     <= '0;
      dbit      <= '0;
      len_left  <= '0;
      wait_cnt  <= '0;
    end else begin
      if (rd_valid && rd_ready) rd_valid <= 1'b0;

      case (state)
        WAKE_CMD: begin
          if (flash_csb) begin
            flash_csb <= 1'b0;
            flash_io0 <= sh_out[31];
            div_cnt   <= '0;
          end else begin
            div_cnt <= tick ? '0 : div_cnt + 8'd1;
            if (rise) begin
              // the slot after the 8th bit is spent low, then CS releases
              if (bit_cnt == 6'd8) begin
                flash_csb <= 1'b1;
                wait_cnt  <= WAKE_LOAD;
                state     <= WAKE_WAIT;
              end else begin
                flash_clk <= 1'b1;
              end
            end else if (fall) begin
              flash_clk <= 1'b0;
              bit_cnt   <= bit_cnt + 6'd1;
              sh_out    <= {sh_out[30:0], 1'b0};
              flash_io0 <= sh_out[30];
            end
          end
        end

        WAKE_WAIT, GAP: begin
          if (wait_cnt == '0) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= READY;
          end else begin
            wait_cnt <= wait_cnt - 16'd1;
          end
        end

        READY: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            flash_csb <= 1'b0;
            flash_io0 <= 1'b0;
            sh_out    <= {8'h03, req_addr};
            div_cnt   <= '0;
            bit_cnt   <= '0;
            dbit      <= '0;
            len_left  <= (req_len == '0) ? 9'd256 : {1'b0, req_len};
            state     <= CMD;
          end
        end

        CMD, ADDR: begin
          div_cnt <= tick ? '0 : div_cnt + 8'd1;
          if (rise) begin
            flash_clk <= 1'b1;
          end else if (fall) begin
            flash_clk <= 1'b0;
            bit_cnt   <= bit_cnt + 6'd1;
            sh_out    <= {sh_out[30:0], 1'b0};
            if (bit_cnt == 6'd31) begin
              flash_io0 <= 1'b0;
              state     <= DATA;
            end else begin
              flash_io0 <= sh_out[30];
              if (bit_cnt == 6'd7) state <= ADDR;
            end
          end
        end

        DATA: begin
          if (!stall) div_cnt <= tick ? '0 : div_cnt + 8'd1;
          if (rise && !stall) begin
            flash_clk <= 1'b1;
          end else if (fall) begin
            flash_clk <= 1'b0;
            if (data_done) state <= END;
          end
          if (sample) begin
            dbit  <= dbit + 3'd1;
            sh_in <= {sh_in[5:0], flash_io1};
            if (dbit == 3'd7) begin
              rd_data  <= {sh_in, flash_io1};
              rd_valid <= 1'b1;
              len_left <= len_left - 9'd1;
            end
          end
        end

        END: begin
          div_cnt <= tick ? '0 : div_cnt + 8'd1;
          if (tick) begin
            flash_csb <= 1'b1;
            wait_cnt  <= GAP_LOAD;
            state     <= GAP;
          end
        end

        default: state <= WAKE_CMD;
      endcase
    end
  end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Synthesizable SPI flash read initiator for the user project area. It drives an external serial flash through user GPIO: the same 4-wire single-I/O protocol the `spiflash` bench model answers. After reset it wakes the flash with a release-power-down command. Each accepted request then issues a READ (0x03) command with a 24-bit address and streams the returned bytes out over a ready/valid interface with backpressure.

## Interface
- `CLK_DIV`, 2: SCK half-period in `clock` cycles; legal range 1..255.
- `GAP_CYC`, 4: minimum `clock` cycles `flash_csb` stays high between transactions; legal range 1..255.
- `WAKE_CYC`, 16: `clock` cycles waited after the wake command before the first request is accepted.
- `clock` in 1: single clock; every flop is on its rising edge.
- `resetb` in 1: asynchronous, active-low reset.
- `req_valid` in 1: read request valid.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_addr` in 24: start byte address.
- `req_len` in 8: byte count; 0 means 256.
- `rd_valid` out 1: `rd_data` holds a byte.
- `rd_ready` in 1: consumer takes the byte when `rd_valid && rd_ready`.
- `rd_data` out 8: read byte.
- `busy` out 1: high in every state except READY.
- `flash_csb` out 1: chip select, active low.
- `flash_clk` out 1: SCK, SPI mode 0 (idle low).
- `flash_io0` out 1: MOSI.
- `flash_io1` in 1: MISO.

## Operation
- Reset values: `flash_csb`=1, `flash_clk`=0, `flash_io0`=0, `req_ready`=0, `rd_valid`=0, `rd_data`=0x00, `busy`=1.
- States are WAKE_CMD → WAKE_WAIT → READY → CMD → ADDR → DATA → END → GAP → READY.
- WAKE_CMD: the block asserts CS and shifts out 0xAB (8 bits), then releases CS.
- WAKE_WAIT: the block counts `GAP_CYC` + `WAKE_CYC` cycles with CS high.
- READY: `req_ready`=1. On acceptance the block latches the address and length (`req_len` 0 maps to 256) and goes to CMD.
- CMD shifts out 0x03. ADDR then shifts out `req_addr[23:0]`. All bits go MSB first.
- DATA shifts in bytes MSB first from `flash_io1`, counting down the remaining length. The flash auto-increments its address; the block never reissues the address.
- Output register: one byte, loaded when a byte's 8th bit is sampled.
  - While `rd_valid && !rd_ready`, the block withholds the 8th rising SCK edge of the next byte, holding `flash_clk` low. No data is lost.
  - A load and a consume in the same cycle are legal; the new byte wins.
- END: SCK returns low, CS deasserts. GAP: CS held high for `GAP_CYC` cycles.
- `flash_io0` is driven 0 during DATA, END and GAP.
- If `resetb` falls mid-transaction, all outputs take their reset values asynchronously and any pending byte is discarded. After release the block restarts at WAKE_CMD.

## Timing
- Bit period is 2·`CLK_DIV` cycles.
  - `flash_io0` changes only on SCK falling edges, or in the cycle CS falls for the first bit.
  - `flash_io1` is sampled in the cycle SCK rises.
- Request accepted in cycle A:
  - `flash_csb` falls in cycle A+1.
  - The k-th rising SCK edge (k=0..) occurs at A+1+`CLK_DIV`+2k·`CLK_DIV`.
- First data byte: `rd_valid` asserts at A+2+79·`CLK_DIV`, which is A+160 for `CLK_DIV`=2.
- Without stalls, each later byte follows the previous one by 16·`CLK_DIV` cycles.
- Transaction end:
  - SCK falls `CLK_DIV` cycles after the last byte's 8th rising edge.
  - `flash_csb` rises `CLK_DIV` cycles after that fall.
  - `req_ready` rises `GAP_CYC` cycles after `flash_csb` rises.
- Wake after reset: `flash_csb` falls 1 cycle after `resetb` deasserts. `req_ready` first rises `CLK_DIV`·17 + `GAP_CYC` + `WAKE_CYC` cycles after that.
- Request versus final byte: `req_ready` stays low until the final byte has been fully sampled. The last `rd_valid` may still be pending when READY is reached. No new request is accepted before CS has been high for `GAP_CYC` cycles.

## Test plan
- Reset release, `spiflash` model attached, `CLK_DIV`=2 → first CS window carries exactly 0xAB. `req_ready` rises 54 cycles after `flash_csb` first falls.
- Request addr 0x000010, len 1, flash[0x10]=0x5A, `rd_ready`=1 → MOSI bits 0x03,0x00,0x00,0x10. `rd_valid` one cycle at A+160 with 0x5A; CS high, then `req_ready` after the gap.
- Request addr 0x000000, len 4, flash holds 0x11,0x22,0x33,0x44, `rd_ready`=1 → four bytes in order, each 32 cycles apart, one CS window.
- Same 4-byte request with `rd_ready`=0 for 200 cycles after the first byte → `flash_clk` frozen low before the 8th edge of byte 2. After release, bytes 0x22,0x33,0x44 arrive with none dropped or duplicated.
- `req_len`=0 from 0x000100 → exactly 256 bytes, matching flash[0x100..0x1FF], then CS rises.
- `resetb` pulsed low mid-ADDR → `flash_csb`=1, `flash_clk`=0, `rd_valid`=0 immediately. After release, the wake sequence repeats, and a subsequent len-1 read returns the correct byte.
